// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF-stage front end owning the PC, fetching over req/gnt/rvalid with one outstanding request.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PC_IF,
  output logic        if_valid,
  output logic        fetch_stall
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HAVE} state_t;
  state_t state, state_nx;
  logic [31:0] pc, inst_reg, pc_reg, rpc;
  logic discard;
  assign rpc = {redirect_pc[31:2], 2'b00};
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = REQ;
      REQ:  state_nx = imem_gnt ? WAIT : REQ;
      WAIT: state_nx = !imem_rvalid ? WAIT : (discard || redirect_valid) ? REQ : HAVE;
      HAVE: state_nx = (redirect_valid || !hold) ? REQ : HAVE;
      default: state_nx = IDLE;
    endcase
  end
  // a redirect arriving while a request is in flight marks its response stale
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc       <= RESET_PC;
      discard  <= 1'b0;
      inst_reg <= 32'h0;
      pc_reg   <= 32'h0;
    end else begin
      if (redirect_valid) pc <= rpc;
      else if (state == HAVE && !hold) pc <= pc + 32'd4;
      if (state == REQ && imem_gnt && redirect_valid) discard <= 1'b1;
      else if (state == WAIT && imem_rvalid) discard <= 1'b0;
      else if (state == WAIT && redirect_valid) discard <= 1'b1;
      if (state == WAIT && imem_rvalid && !discard && !redirect_valid) begin
        inst_reg <= imem_rdata;
        pc_reg   <= pc;
      end
    end
  always_comb begin
    imem_req    = state == REQ;
    imem_addr   = pc;
    if_valid    = state == HAVE;
    fetch_stall = state != HAVE;
    Instruction = state == HAVE ? inst_reg : 32'h0;
    PC_IF       = state == HAVE ? pc_reg : 32'h0;
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed table, corner sequences and randomized scoreboard checks for if_fetch_unit.
module tb_if_fetch_unit;
  localparam logic [31:0] A = 32'hA000_0000;
  logic clk = 0, reset = 0, hold = 0, redirect_valid = 0, imem_gnt = 0, imem_rvalid = 0;
  logic [31:0] redirect_pc = 0, imem_rdata = 0;
  logic imem_req, if_valid, fetch_stall;
  logic [31:0] imem_addr, Instruction, PC_IF;
  int passes = 0, total = 0;
  always #5 clk = ~clk;
  if_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .hold(hold), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .Instruction(Instruction), .PC_IF(PC_IF), .if_valid(if_valid), .fetch_stall(fetch_stall));
  typedef struct {
    logic hold, rv; logic [31:0] rpc; logic gnt, rvalid; logic [31:0] rdata;
    logic req; logic [31:0] addr; logic valid; logic [31:0] inst, pc;
  } vec_t;
  vec_t tbl [29];
  function automatic vec_t mk(input logic h, rv, input logic [31:0] rpc, input logic g, rvl,
                              input logic [31:0] rd, input logic rq, input logic [31:0] ad,
                              input logic vl, input logic [31:0] in, pcv);
    vec_t v;
    v.hold = h; v.rv = rv; v.rpc = rpc; v.gnt = g; v.rvalid = rvl; v.rdata = rd;
    v.req = rq; v.addr = ad; v.valid = vl; v.inst = in; v.pc = pcv;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic drive(input logic h, rv, input logic [31:0] rpc, input logic g, rvl, input logic [31:0] rd);
    hold = h; redirect_valid = rv; redirect_pc = rpc; imem_gnt = g; imem_rvalid = rvl; imem_rdata = rd;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string nm, input logic rq, input logic [31:0] ad, input logic vl,
                         input logic [31:0] in, pcv);
    chk({nm, ".req"}, {31'b0, imem_req}, {31'b0, rq});
    if (rq) chk({nm, ".addr"}, imem_addr, ad);
    chk({nm, ".valid"}, {31'b0, if_valid}, {31'b0, vl});
    chk({nm, ".stall"}, {31'b0, fetch_stall}, {31'b0, !vl});
    chk({nm, ".inst"}, Instruction, in);
    chk({nm, ".pc"}, PC_IF, pcv);
  endtask
  task automatic chk_reset(input string nm);
    chk_out(nm, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk({nm, ".addr_rst"}, imem_addr, 32'h0);
  endtask

  logic pend, rv_q, gnt_q, req_q, hold_q, valid_q;
  int lat, presents;
  logic [31:0] pdata, exp_pc, addr_q, pcif_q, inst_q;

  initial begin
    tbl[0]  = mk(0,0,0,0,0,0,         0,0,0,0,0);
    tbl[1]  = mk(0,0,0,1,0,0,         1,0,0,0,0);
    tbl[2]  = mk(0,0,0,0,1,A,         0,0,0,0,0);
    tbl[3]  = mk(0,0,0,0,0,0,         0,0,1,A,0);
    tbl[4]  = mk(0,0,0,1,0,0,         1,4,0,0,0);
    tbl[5]  = mk(0,0,0,0,1,A|4,       0,0,0,0,0);
    for (int i = 6; i <= 10; i++) tbl[i] = mk(1,0,0,0,0,0, 0,0,1,A|4,4);
    tbl[11] = mk(0,0,0,0,0,0,         0,0,1,A|4,4);
    tbl[12] = mk(0,0,0,1,0,0,         1,8,0,0,0);
    tbl[13] = mk(0,1,'h100,0,0,0,     0,0,0,0,0);
    tbl[14] = mk(0,0,0,0,1,A|8,       0,0,0,0,0);
    tbl[15] = mk(0,0,0,1,0,0,         1,'h100,0,0,0);
    tbl[16] = mk(0,0,0,0,1,A|'h100,   0,0,0,0,0);
    tbl[17] = mk(0,0,0,0,0,0,         0,0,1,A|'h100,'h100);
    tbl[18] = mk(0,0,0,0,0,0,         1,'h104,0,0,0);
    tbl[19] = mk(0,1,'h203,0,0,0,     1,'h104,0,0,0);
    tbl[20] = mk(0,0,0,0,0,0,         1,'h200,0,0,0);
    tbl[21] = mk(0,0,0,1,0,0,         1,'h200,0,0,0);
    tbl[22] = mk(0,0,0,0,1,A|'h200,   0,0,0,0,0);
    tbl[23] = mk(1,1,'hFFFF_FFFE,0,0,0, 0,0,1,A|'h200,'h200);
    tbl[24] = mk(0,0,0,1,0,0,         1,'hFFFF_FFFC,0,0,0);
    tbl[25] = mk(0,0,0,0,1,'hFFFF_FFFC, 0,0,0,0,0);
    tbl[26] = mk(0,0,0,0,0,0,         0,0,1,'hFFFF_FFFC,'hFFFF_FFFC);
    tbl[27] = mk(0,0,0,1,0,0,         1,0,0,0,0);
    tbl[28] = mk(0,0,0,0,0,0,         0,0,0,0,0);
    step; step;
    chk_reset("reset0");
    reset = 1;
    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].hold, tbl[i].rv, tbl[i].rpc, tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata);
      chk_out($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].inst, tbl[i].pc);
      step;
    end
    // reset pulsed while a request is in flight, stale rvalid afterwards
    drive(0,0,0,0,0,0);
    #2 reset = 0;
    #1 chk_reset("async_rst");
    step;
    reset = 1;
    drive(0,0,0,0,1,32'hDEAD_BEEF); chk_out("rst_idle", 0,0,0,0,0); step;
    drive(0,0,0,0,1,32'hDEAD_BEEF); chk_out("rst_req", 1,0,0,0,0); step;
    drive(0,0,0,1,0,0);             chk_out("rst_req2", 1,0,0,0,0); step;
    drive(0,0,0,0,1,A);             chk_out("rst_wait", 0,0,0,0,0); step;
    drive(0,0,0,0,0,0);             chk_out("rst_have", 0,0,1,A,0); step;
    // redirect in the same cycle as the grant makes the granted fetch stale
    drive(0,1,'h40,1,0,0);          chk_out("rg_req", 1,4,0,0,0); step;
    drive(0,0,0,0,1,A|4);           chk_out("rg_wait", 0,0,0,0,0); step;
    drive(0,0,0,1,0,0);             chk_out("rg_req2", 1,'h40,0,0,0); step;
    drive(0,0,0,0,1,A|'h40);        chk_out("rg_wait2", 0,0,0,0,0); step;
    drive(0,0,0,0,0,0);             chk_out("rg_have", 0,0,1,A|'h40,'h40); step;
    // randomized run against a transaction-level scoreboard
    reset = 0; step; reset = 1;
    pend = 0; lat = 0; pdata = 0; exp_pc = 0; presents = 0;
    rv_q = 0; gnt_q = 0; req_q = 0; hold_q = 0; valid_q = 0; addr_q = 0; pcif_q = 0; inst_q = 0;
    for (int c = 0; c < 3000; c++) begin
      imem_rvalid = pend && lat == 1;
      imem_rdata  = imem_rvalid ? pdata : $urandom;
      imem_gnt    = imem_req && $urandom_range(0, 1) == 1;
      hold        = $urandom_range(0, 9) < 3;
      redirect_valid = $urandom_range(0, 19) == 0;
      redirect_pc = $urandom;
      if (fetch_stall !== !if_valid) chk("r.stall", {31'b0, fetch_stall}, {31'b0, !if_valid});
      if (!if_valid && (Instruction !== 0 || PC_IF !== 0)) chk("r.nop", Instruction | PC_IF, 32'h0);
      if (if_valid && !valid_q) begin
        presents++;
        chk("r.pc", PC_IF, exp_pc);
        chk("r.inst", Instruction, exp_pc | A);
      end
      if (valid_q && hold_q && !rv_q) begin
        chk("r.hold_valid", {31'b0, if_valid}, 32'h1);
        chk("r.hold_pc", PC_IF, pcif_q);
        chk("r.hold_req", {31'b0, imem_req}, 32'h0);
      end
      if (req_q && !gnt_q && !rv_q) begin
        chk("r.req_kept", {31'b0, imem_req}, 32'h1);
        chk("r.addr_kept", imem_addr, addr_q);
      end
      if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
      else if (if_valid && !hold) exp_pc = PC_IF + 32'd4;
      rv_q = redirect_valid; gnt_q = imem_gnt; req_q = imem_req; hold_q = hold;
      valid_q = if_valid; addr_q = imem_addr; pcif_q = PC_IF; inst_q = Instruction;
      step;
      if (gnt_q) begin
        pend = 1; lat = $urandom_range(1, 3); pdata = addr_q | A;
      end else if (pend) begin
        if (lat == 1) pend = 0;
        else lat--;
      end
    end
    chk("r.progress", {31'b0, presents > 100}, 32'h1);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage front end for the 5-stage MIPS pipeline. It owns the PC register, issues word fetches to instruction memory over a request/grant/response handshake, and presents the fetched Instruction and PC_IF to the IF/ID pipeline register. It honours the hazard unit's hold and the branch/jump redirect, and reports fetch_stall when no instruction is available. It has at most one outstanding memory request.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; low 2 bits must be 0.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
hold  in  1  pipeline hold from the hazard unit (same signal as the IF/ID hold); freezes the presented instruction and PC.
redirect_valid  in  1  branch/jump taken this cycle.
redirect_pc  in  32  target address; bits [1:0] ignored (treated as 0).
imem_req  out  1  fetch request.
imem_addr  out  32  word address of the request; held stable while imem_req=1 and imem_gnt=0.
imem_gnt  in  1  memory accepts the request this cycle.
imem_rvalid  in  1  read data valid; earliest one cycle after gnt.
imem_rdata  in  32  fetched instruction word.
Instruction  out  32  instruction to IF/ID; 32'h0 (nop) when if_valid=0.
PC_IF  out  32  address of Instruction; 0 when if_valid=0.
if_valid  out  1  Instruction/PC_IF hold a real fetched instruction.
fetch_stall  out  1  equals !if_valid; the hazard unit uses it to insert a bubble.

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, state=IDLE, discard=0, imem_req=0, imem_addr=RESET_PC, Instruction=0, PC_IF=0, if_valid=0, fetch_stall=1.
- States: IDLE, REQ, WAIT, HAVE.
- IDLE: one cycle after reset deassertion -> REQ.
- REQ: imem_req=1, imem_addr=pc.
  - If imem_gnt=1 -> WAIT.
  - If redirect_valid=1 in the same cycle as gnt, the granted request is stale: discard=1, pc=redirect_pc, -> WAIT.
  - If redirect_valid=1 with no gnt: pc=redirect_pc, stay in REQ; imem_addr updates the next cycle. This is the only permitted address change while the request is ungranted.
- WAIT: imem_req=0.
  - On imem_rvalid with discard=0: inst_reg=imem_rdata, pc_reg=pc -> HAVE.
  - On imem_rvalid with discard=1: drop the data, discard=0 -> REQ.
  - On redirect_valid while in WAIT: discard=1, pc=redirect_pc. If rvalid arrives in the same cycle, the data is dropped.
- HAVE: if_valid=1, Instruction=inst_reg, PC_IF=pc_reg.
  - hold=1 and no redirect: outputs frozen, stay in HAVE.
  - hold=0: pc=pc+4 -> REQ.
  - redirect_valid=1: overrides hold. Drop the instruction, pc=redirect_pc -> REQ.
- Redirect priority: redirect_valid beats hold and the sequential pc+4 in every state.
- hold has no effect in REQ or WAIT; fetch continues so the instruction is ready when hold drops.
- Arithmetic: pc+4 is modulo 2^32 (32'hFFFF_FFFC + 4 = 0). redirect_pc[1:0] is forced to 2'b00.
- Outputs are registered. if_valid rises on the cycle after rvalid is accepted.
- Minimum fetch loop with 1-cycle memory: 3 cycles per instruction (REQ, WAIT, HAVE).
- Reset asserted mid-operation: immediate return to reset values. Any in-flight memory response that arrives after reset deassertion, before the first new gnt, is ignored (rvalid is only sampled in WAIT).

Test Plan:
- Reset release with RESET_PC=0 and 1-cycle memory returning rdata=addr|32'hA000_0000 -> imem_addr sequence 0,4,8; Instruction 32'hA000_0000, 32'hA000_0004, 32'hA000_0008 each with if_valid=1 and PC_IF matching; fetch_stall=1 in all other cycles.
- hold=1 for 5 cycles while in HAVE with PC_IF=4 -> Instruction and PC_IF stay constant and no imem_req. After hold drops, next imem_addr=8.
- redirect_valid=1, redirect_pc=32'h100 while in WAIT for address 8 -> the rvalid data for 8 is dropped (if_valid stays 0), next imem_addr=32'h100, then PC_IF=32'h100.
- gnt held low 3 cycles with redirect_pc=32'h203 in the second cycle -> imem_addr=32'h200 from the next cycle; the granted address is 32'h200.
- pc=32'hFFFF_FFFC fetched, hold=0 -> next imem_addr=0.
- reset pulsed low while in WAIT, and memory asserts rvalid after release -> outputs return to reset values, the stale rvalid is ignored, and the first request is issued at RESET_PC.
